wrr_pkt_scheduler: RTL
======================

Name: wrr_pkt_scheduler

Overview:
Packet-level weighted round-robin scheduler that shares one downstream beat channel between WIDTH requesters.
- Each requester owns a credit counter, reloaded from its configured weight.
- A grant locks the channel to one requester until that requester's last beat is accepted.
- Sits between the requester FIFOs and the shared output mux; grant drives the mux select.

Parameters:
WIDTH, 4, number of requesters
CRD_WIDTH, 4, width of each weight/credit counter
TOTAL_WIDTH, CRD_WIDTH*WIDTH, packed weight bus width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low; state clears immediately when rst=0, released synchronously by the driver
credits  input  TOTAL_WIDTH  packed weights, requester i at [i*CRD_WIDTH +: CRD_WIDTH]; sampled only on reload
req  input  WIDTH  requester i has a packet/beat pending
last  input  WIDTH  requester i's current beat is the final beat of its packet
out_ready  input  1  downstream accepts a beat this cycle
grant  output  WIDTH  registered one-hot owner of the channel, 0 when idle
out_valid  output  1  |(req & grant), combinational
credit_avail  output  WIDTH  bit i = (counter i != 0), from registers
busy  output  1  registered, 1 while in LOCK

Behaviour:
- Reset values: grant=0, busy=0, all counters=0, credit_avail=0, state=IDLE, rr pointer=WIDTH-1 (requester 0 has highest priority first).
- States:
  - IDLE: grant=0.
  - RELOAD: single cycle, grant=0.
  - LOCK: grant is held.
- IDLE, eligible = req & credit_avail:
  - eligible != 0: pick the first set bit scanning upward from pointer+1 with wrap-around. grant <= one-hot winner, go to LOCK. Grant is visible the cycle after the request is seen (1-cycle latency).
  - eligible == 0 and req != 0: go to RELOAD.
  - req == 0: stay in IDLE.
- RELOAD: every counter <= its credits field (all requesters, not only requesting ones). Go to IDLE. Request-to-grant latency on a reload path is 3 cycles.
- LOCK: a beat transfers when out_valid & out_ready.
  - Transfer with last[owner]=1: owner counter decrements by 1 (saturates at 0), pointer <= owner index, grant <= 0, go to IDLE.
  - Transfer with last=0: stay in LOCK.
  - Owner deasserts req mid-packet: out_valid=0, grant held, no timeout.
  - Requests from other requesters are ignored until the packet ends.
- Back-to-back packets: after a packet ends there is at least one IDLE cycle, so the minimum gap between grants is 1 cycle.
- Weight 0: counter reloads to 0, so that requester is never granted. If every requesting index has weight 0, the block cycles IDLE->RELOAD indefinitely with grant=0. This is legal and must not hang or X.
- Changes on credits take effect only at the next RELOAD.
- Async reset mid-packet: grant drops to 0 immediately and counters clear. The partial packet is lost; the upstream is responsible for it.
- grant is always one-hot or zero; an assertion checks this.

Decomposition:
- Shared package wrr_pkg:
  - state enum IDLE/RELOAD/LOCK, 2-bit encoding
  - localparam for pointer width, $clog2(WIDTH)
  - function onehot_to_idx
- One sub-module, rr_priority_pick: combinational masked priority picker.
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot winner and a valid flag.
  - Reused by later arbiters.
- Counters, FSM and pointer stay in the top module.

Test Plan:
- Startup reload, WIDTH=2, credits={4'd2,4'd1}. req=01 after reset: cycle 0 RELOAD, cycle 2 grant=01. Send a single-beat packet with last=1, out_ready=1: credit_avail becomes 10 afterwards.
- Weighting: req=11 held, all packets single-beat. Grant sequence is 01,10,10, then reload, then repeats. Requester 1 gets 2 packets per 1 for requester 0.
- Packet lock: owner=01 sends a 4-beat packet while req[1]=1. out_ready toggles 1,0,1,0,1,1. grant stays 01 until the 4th accepted beat (last=1), then 0 for one cycle, then 10.
- Owner stall: owner drops req for 3 cycles mid-packet. out_valid=0 and grant unchanged; the packet resumes and completes normally.
- Zero weight: credits={4'd0,4'd3}, req=10. grant stays 0 forever, state alternates IDLE/RELOAD, no X. Then req=11: requester 0 is granted.
- Async reset: assert rst=0 mid-packet between clock edges. grant=0, busy=0 and credit_avail=0 immediately. After release the next request goes through RELOAD.

Source files
------------

// File: rtl/wrr_pkt_scheduler_pkg.sv
// Shared types and helpers for the weighted round-robin packet scheduler
// and the arbiters built on its priority picker.
package wrr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RELOAD = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam int WRR_WIDTH = 4;
  localparam int PTR_W     = $clog2(WRR_WIDTH);

  // Index of the set bit of a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_pkt_scheduler_rr_priority_pick.sv
// Combinational round-robin picker: first set bit of i_eligible scanning
// upward from i_ptr+1 with wrap-around.
module rr_priority_pick
  import wrr_pkg::*;
#(
  parameter int WIDTH  = WRR_WIDTH,
  parameter int PTR_W_P = PTR_W
) (
  input  logic [WIDTH-1:0]   i_eligible,
  input  logic [PTR_W_P-1:0] i_ptr,
  output logic [WIDTH-1:0]   o_winner,
  output logic               o_valid
);

  logic [PTR_W_P:0]     w_sh;
  logic [2*WIDTH-1:0]   w_dbl;
  logic [2*WIDTH-1:0]   w_back;
  logic [WIDTH-1:0]     w_rot;
  logic [WIDTH-1:0]     w_rot_oh;

  // Rotate so the highest-priority requester sits at bit 0, isolate the
  // lowest set bit, then rotate back into requester order.
  always_comb begin
    w_sh     = {1'b0, i_ptr} + 1'b1;
    w_dbl    = {i_eligible, i_eligible} >> w_sh;
    w_rot    = w_dbl[WIDTH-1:0];
    w_rot_oh = w_rot & (~w_rot + WIDTH'(1));
    w_back   = {w_rot_oh, w_rot_oh} << w_sh;
    o_winner = w_back[2*WIDTH-1:WIDTH];
    o_valid  = |i_eligible;
  end

endmodule

// File: rtl/wrr_pkt_scheduler.sv
// Packet-level weighted round-robin scheduler: a grant owns the shared beat
// channel until the owner's last beat is accepted; credits gate eligibility.
module wrr_pkt_scheduler
  import wrr_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CRD_WIDTH = 4,
  localparam int TOTAL_WIDTH = CRD_WIDTH * WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TOTAL_WIDTH-1:0] credits,
  input  logic [WIDTH-1:0]       req,
  input  logic [WIDTH-1:0]       last,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       grant,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       credit_avail,
  output logic                   busy
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_grant, w_grant_nxt;
  logic [PW-1:0]        r_ptr, w_ptr_nxt;
  logic [CRD_WIDTH-1:0] r_cnt [WIDTH];
  logic                 r_busy;
  logic                 w_reload, w_dec;
  logic [WIDTH-1:0]     w_eligible, w_winner;
  logic                 w_win_vld, w_xfer, w_owner_last;
  logic [PW-1:0]        w_owner_idx;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      credit_avail[i] = |r_cnt[i];
    end
  end

  assign w_eligible   = req & credit_avail;
  assign out_valid    = |(req & r_grant);
  assign w_xfer       = out_valid & out_ready;
  assign w_owner_last = |(last & r_grant);
  assign w_owner_idx  = PW'(onehot_to_idx(32'(r_grant)));
  assign grant        = r_grant;
  assign busy         = r_busy;

  rr_priority_pick #(
    .WIDTH   (WIDTH),
    .PTR_W_P (PW)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_winner   (w_winner),
    .o_valid    (w_win_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_reload    = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        if (w_win_vld) begin
          w_grant_nxt = w_winner;
          w_state_nxt = LOCK;
        end else if (|req) begin
          w_state_nxt = RELOAD;
        end
      end
      RELOAD: begin
        w_reload    = 1'b1;
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
      LOCK: begin
        // Other requesters are ignored; only the owner's final beat releases.
        if (w_xfer && w_owner_last) begin
          w_dec       = 1'b1;
          w_ptr_nxt   = w_owner_idx;
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(WIDTH - 1);
      r_busy  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == LOCK);
      for (int i = 0; i < WIDTH; i++) begin
        if (w_reload)
          r_cnt[i] <= credits[i*CRD_WIDTH +: CRD_WIDTH];
        else if (w_dec && r_grant[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_grant));

endmodule
